// File: rtl/irrigation_pkg.sv
// Shared constants and types for the LED-matrix scan capture block.
//   NUM_COLS / NUM_ROWS / FRAME_W : matrix geometry (5 columns x 7 rows)
//   ERR_*                         : err_code values reported by the capture block
//   scan_state_t                  : capture FSM state encoding
package irrigation_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int FRAME_W  = NUM_COLS * NUM_ROWS;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MULTI   = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WAIT_NEXT
  } scan_state_t;

endpackage

// File: rtl/matrix_scan_capture_sync2.sv
// sync2: parameterised-width two-flop synchroniser.
// Ports:
//   clk_i  in   1      sampling clock
//   rst_i  in   1      asynchronous reset, active-high
//   d_i    in   WIDTH  asynchronous input bus
//   q_o    out  WIDTH  synchronised output, two clk_i cycles behind d_i
// RST_VAL sets the value both stages take in reset, so an active-low bus can
// come out of reset at its idle level instead of looking asserted.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: receive side of the 5x7 LED-matrix column-scan bus.
// Rebuilds the 35-pixel frame from one C0..C4 sweep and flags malformed scans.
// Ports:
//   clk            in   1   system clock
//   rst            in   1   asynchronous reset, active-high
//   col_in         in   5   C4..C0 column strobes (async)
//   row_in         in   7   l6..l0 row lines (async)
//   frame          out  35  last committed frame, bit = col*7+row, 1 = lit
//   frame_valid    out  1   one-cycle pulse on frame update
//   locked         out  1   high after a commit, low after an error or reset
//   scan_err       out  1   one-cycle error pulse
//   err_code       out  2   01 multi-hot, 10 out-of-order, 11 timeout (held)
//   frame_changed  out  1   only with FRAME_DIFF_EN: pulses with frame_valid
//                           when the new frame differs from the previous one
// Build option: define FRAME_DIFF_EN to add frame_changed.
//
// state     | meaning
// IDLE      | waiting for a one-hot C0 to start a sweep
// SETTLE    | current column active, counting stable cycles
// SAMPLE    | one cycle: store rows of current column, commit after C4
// WAIT_NEXT | column stored, waiting for the next column strobe
module matrix_scan_capture
  import irrigation_pkg::*;
#(
  parameter int SETTLE_CYC     = 4,
  parameter int TIMEOUT_CYC    = 1000000,
  parameter bit COL_ACTIVE_LOW = 1'b0,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         col_in,
  input  logic [6:0]         row_in,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  output logic               locked,
  output logic               scan_err,
  output logic [1:0]         err_code
`ifdef FRAME_DIFF_EN
  ,
  output logic               frame_changed
`endif
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // The cycle in which a column is accepted is already its first stable
  // cycle, so the settle counter starts at SETTLE_CYC-1 remaining.
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  // Likewise the accept cycle is the first timeout cycle and the cycle that
  // sees zero is the last, hence the -2.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 2);

  localparam logic [NUM_COLS+NUM_ROWS-1:0] SYNC_IDLE =
    {{NUM_COLS{COL_ACTIVE_LOW}}, {NUM_ROWS{ROW_ACTIVE_LOW}}};

  logic [NUM_COLS+NUM_ROWS-1:0] sync_w;
  logic [NUM_COLS-1:0]          col_n;
  logic [NUM_ROWS-1:0]          row_n;

  sync2 #(
    .WIDTH   (NUM_COLS + NUM_ROWS),
    .RST_VAL (SYNC_IDLE)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({col_in, row_in}),
    .q_o   (sync_w)
  );

  assign col_n = sync_w[NUM_COLS+NUM_ROWS-1:NUM_ROWS] ^ {NUM_COLS{COL_ACTIVE_LOW}};
  assign row_n = sync_w[NUM_ROWS-1:0] ^ {NUM_ROWS{ROW_ACTIVE_LOW}};

  // Column code decode
  logic       col_blank;
  logic       col_multi;
  logic       col_one;
  logic [2:0] col_idx;

  always_comb begin
    col_blank = (col_n == '0);
    col_multi = !col_blank && ((col_n & (col_n - 5'd1)) != '0);
    col_one   = !col_blank && !col_multi;
    col_idx   = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_n[i]) col_idx = i[2:0];
    end
  end

  scan_state_t        state_q, state_d;
  logic [2:0]         cur_q, cur_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               prev_blank_q;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               fv_q, fv_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic [2:0] nxt_idx;
  logic       accept;
  logic [1:0] err_kind;

  assign nxt_idx = cur_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    set_d    = set_q;
    tmo_d    = tmo_q;
    buf_d    = buf_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    code_d   = code_q;
    accept   = 1'b0;
    err_kind = ERR_NONE;

    // Stall window runs from the accept through SAMPLE as well, so it is
    // measured from the moment the column was taken, not from its sampling.
    if (state_q != IDLE && tmo_q != '0) tmo_d = tmo_q - TMO_W'(1);

    case (state_q)
      IDLE: begin
        if (col_one && col_idx == 3'd0) begin
          cur_d   = '0;
          set_d   = SET_LOAD;
          tmo_d   = TMO_LOAD;
          buf_d   = '0;
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (col_one) begin
          if (col_idx == cur_q) begin
            if (prev_blank_q)              set_d = SET_LOAD;
            else if (set_q <= SET_W'(1))   state_d = SAMPLE;
            else                           set_d = set_q - SET_W'(1);
          end else if (col_idx == nxt_idx) begin
            cur_d  = nxt_idx;
            set_d  = SET_LOAD;
            tmo_d  = TMO_LOAD;
            accept = 1'b1;
          end else begin
            err_kind = ERR_ORDER;
          end
        end
      end
      SAMPLE: begin
        for (int k = 0; k < NUM_COLS; k++) begin
          if (cur_q == k[2:0]) buf_d[k*NUM_ROWS +: NUM_ROWS] = row_n;
        end
        if (cur_q == 3'(NUM_COLS - 1)) begin
          frame_d  = buf_d;
          fv_d     = 1'b1;
          locked_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT_NEXT;
        end
      end
      WAIT_NEXT: begin
        if (col_one) begin
          if (col_idx == nxt_idx) begin
            cur_d   = nxt_idx;
            set_d   = SET_LOAD;
            tmo_d   = TMO_LOAD;
            accept  = 1'b1;
            state_d = SETTLE;
          end else if (col_idx != cur_q) begin
            err_kind = ERR_ORDER;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // SAMPLE skips column checks so a commit never coincides with an error.
    if (state_q != SAMPLE && col_multi) err_kind = ERR_MULTI;
    if (err_kind == ERR_NONE && !accept && tmo_q == '0 &&
        (state_q == SETTLE || state_q == WAIT_NEXT)) err_kind = ERR_TIMEOUT;

    if (err_kind != ERR_NONE) begin
      err_d    = 1'b1;
      code_d   = err_kind;
      locked_d = 1'b0;
      state_d  = IDLE;
      buf_d    = '0;
      cur_d    = '0;
      set_d    = '0;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      set_q        <= '0;
      tmo_q        <= '0;
      prev_blank_q <= 1'b1;
      buf_q        <= '0;
      frame_q      <= '0;
      fv_q         <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      set_q        <= set_d;
      tmo_q        <= tmo_d;
      prev_blank_q <= col_blank;
      buf_q        <= buf_d;
      frame_q      <= frame_d;
      fv_q         <= fv_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      code_q       <= code_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign scan_err    = err_q;
  assign err_code    = code_q;

`ifdef FRAME_DIFF_EN
  logic have_q, have_d;
  logic chg_q, chg_d;

  // The first commit after reset has nothing to compare against.
  always_comb begin
    have_d = have_q | fv_d;
    chg_d  = fv_d && (!have_q || frame_d != frame_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      have_q <= have_d;
      chg_q  <= chg_d;
    end
  end

  assign frame_changed = chg_q;
`endif

endmodule

// File: tb/tb_matrix_scan_capture.sv
module tb_matrix_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  col_in;
  logic [6:0]  row_in;
  logic [34:0] frame;
  logic        frame_valid;
  logic        locked;
  logic        scan_err;
  logic [1:0]  err_code;
`ifdef FRAME_DIFF_EN
  logic        frame_changed;
`endif

  matrix_scan_capture #(
    .SETTLE_CYC     (4),
    .TIMEOUT_CYC    (50),
    .COL_ACTIVE_LOW (1'b0),
    .ROW_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .row_in      (row_in),
    .frame       (frame),
    .frame_valid (frame_valid),
    .locked      (locked),
    .scan_err    (scan_err),
    .err_code    (err_code)
`ifdef FRAME_DIFF_EN
    ,
    .frame_changed (frame_changed)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters, sampled mid-cycle
  int fv_cnt  = 0;
  int err_cnt = 0;
`ifdef FRAME_DIFF_EN
  int chg_cnt = 0;
`endif

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (scan_err === 1'b1) err_cnt++;
`ifdef FRAME_DIFF_EN
    if (frame_changed === 1'b1) chg_cnt++;
`endif
  end

  // Reference model: what the display monitor should be reporting
  logic [34:0] m_frame  = '0;
  logic [1:0]  m_code   = 2'b00;
  logic        m_locked = 1'b0;
  int fv_base, err_base;
`ifdef FRAME_DIFF_EN
  bit m_have = 1'b0;
  int chg_base;
  int exp_chg;
`endif

  task automatic drive(input logic [4:0] c, input logic [6:0] r, input int n);
    col_in = c;
    row_in = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_trial();
    fv_base  = fv_cnt;
    err_base = err_cnt;
`ifdef FRAME_DIFF_EN
    chg_base = chg_cnt;
    exp_chg  = 0;
`endif
  endtask

  task automatic end_checks(input string tag, input int exp_fv, input int exp_err);
    check_val({tag, "_fv"}, 35'(fv_cnt - fv_base), 35'(exp_fv));
    check_val({tag, "_err"}, 35'(err_cnt - err_base), 35'(exp_err));
    check_val({tag, "_frame"}, frame, m_frame);
    check_val({tag, "_locked"}, 35'(locked), 35'(m_locked));
    check_val({tag, "_code"}, 35'(err_code), 35'(m_code));
`ifdef FRAME_DIFF_EN
    check_val({tag, "_changed"}, 35'(chg_cnt - chg_base), 35'(exp_chg));
`endif
  endtask

  // Drive columns 0..ncols-1 with the rows taken from a frame-format vector.
  task automatic drive_cols(input logic [34:0] rows, input int ncols, input bit fixed);
    logic [4:0] c;
    for (int k = 0; k < ncols; k++) begin
      c = 5'b00001 << k;
      if (!fixed) drive(5'b0, rows[k*7 +: 7], $urandom_range(0, 3));
      drive(c, rows[k*7 +: 7], fixed ? 10 : $urandom_range(6, 14));
    end
  endtask

  task automatic model_commit(input logic [34:0] rows);
`ifdef FRAME_DIFF_EN
    if (!m_have || rows != m_frame) exp_chg++;
    m_have = 1'b1;
`endif
    m_frame  = rows;
    m_locked = 1'b1;
  endtask

  function automatic logic [34:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[34:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] rows;
    logic [4:0]  v;
    int          j, w, found, kind;

    rst = 1'b1;
    col_in = '0;
    row_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_frame", frame, '0);
    check_val("rst_fv", 35'(frame_valid), 35'(0));
    check_val("rst_locked", 35'(locked), 35'(0));
    check_val("rst_err", 35'(scan_err), 35'(0));
    check_val("rst_code", 35'(err_code), 35'(0));
    rst = 1'b0;
    drive(5'b0, 7'h0, 4);

    // Clean fixed sweep, diagonal pattern; frame_valid 2+4+1 cycles after C4
    start_trial();
    rows = '0;
    for (int k = 0; k < 5; k++) rows[k*8] = 1'b1;
    drive_cols(rows, 4, 1'b1);
    col_in = 5'b10000;
    row_in = 7'h10;
    found = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (found == 0 && frame_valid === 1'b1) found = i;
    end
    check_val("fv_latency", 35'(found), 35'(7));
    drive(5'b0, 7'h0, 6);
    model_commit(rows);
    end_checks("diag", 1, 0);

    // Stall: C0 then blanking -> timeout 50 cycles after C0 accepted
    start_trial();
    col_in = 5'b00001;
    row_in = 7'h55;
    found = 0;
    for (int i = 1; i <= 120 && found == 0; i++) begin
      @(negedge clk);
      if (i == 10) col_in = 5'b0;
      if (scan_err === 1'b1) found = i;
    end
    check_val("tmo_latency", 35'(found), 35'(52));
    drive(5'b0, 7'h0, 4);
    m_code = 2'b11;
    m_locked = 1'b0;
    end_checks("tmo", 0, 1);

    // Glitch: short C1 strobe, blanking, then C1 again; rows from second strobe
    start_trial();
    rows = rand_frame();
    drive(5'b00001, rows[6:0], 10);
    drive(5'b00010, 7'h2a, 3);
    drive(5'b0, 7'h2a, 3);
    drive(5'b00010, ~rows[13:7], 2);
    drive(5'b00010, rows[13:7], 8);
    for (int k = 2; k < 5; k++) drive(5'b00001 << k, rows[k*7 +: 7], 10);
    drive(5'b0, 7'h0, 6);
    model_commit(rows);
    end_checks("glitch", 1, 0);

    // Randomised sweeps, out-of-order and multi-hot faults
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      start_trial();
      if (kind == 0) begin
        rows = rand_frame();
        drive_cols(rows, 5, 1'b0);
        drive(5'b0, 7'h0, 6);
        model_commit(rows);
        end_checks("sweep", 1, 0);
      end else if (kind == 1) begin
        j = $urandom_range(1, 4);
        drive_cols(rand_frame(), j, 1'b0);
        do w = $urandom_range(1, 4); while (w == j - 1 || w == j);
        drive(5'b00001 << w, 7'($urandom_range(0, 127)), 8);
        drive(5'b0, 7'h0, 6);
        m_code = 2'b10;
        m_locked = 1'b0;
        end_checks("order", 0, 1);
      end else begin
        j = $urandom_range(1, 4);
        drive_cols(rand_frame(), j, 1'b0);
        do v = 5'($urandom_range(0, 31)); while ($countones(v) < 2);
        drive(v, 7'($urandom_range(0, 127)), 1);
        drive(5'b0, 7'h0, 8);
        m_code = 2'b01;
        m_locked = 1'b0;
        end_checks("multi", 0, 1);
      end
    end

    // Reset in the middle of C3 clears outputs at once
    rows = rand_frame();
    drive_cols(rows, 3, 1'b1);
    drive(5'b01000, rows[27:21], 3);
    #2 rst = 1'b1;
    #1;
    check_val("arst_frame", frame, '0);
    check_val("arst_locked", 35'(locked), 35'(0));
    check_val("arst_code", 35'(err_code), 35'(0));
    check_val("arst_fv", 35'(frame_valid), 35'(0));
    col_in = 5'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_frame = '0;
    m_code = 2'b00;
    m_locked = 1'b0;
`ifdef FRAME_DIFF_EN
    m_have = 1'b0;
`endif
    drive(5'b0, 7'h0, 4);

    // Two identical sweeps after reset
    for (int s = 0; s < 2; s++) begin
      start_trial();
      drive_cols(rows, 5, 1'b0);
      drive(5'b0, 7'h0, 6);
      model_commit(rows);
      end_checks("post_rst", 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
